// File: rtl/fxp_mult_seq.sv
// Iterative signed fixed-point multiplier with configurable formats.
// Uses one shift-add step per bit of b, then one normalise cycle for rounding and saturation.
module fxp_mult_seq #(
  parameter int A_W      = 7,
  parameter int A_FRAC   = 4,
  parameter int B_W      = 14,
  parameter int B_FRAC   = 10,
  parameter int OUT_W    = 14,
  parameter int OUT_FRAC = 10,
  parameter int ROUND    = 1,
  parameter int SAT      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic             out_ovf
);

  localparam int P_W  = A_W + B_W;
  localparam int S    = A_FRAC + B_FRAC - OUT_FRAC;
  localparam int SH_R = (S > 0) ? S : 0;
  localparam int SH_L = (S < 0) ? -S : 0;
  localparam int N0   = P_W + 1 + SH_L;
  localparam int NW   = (N0 > OUT_W + 1) ? N0 : OUT_W + 1;
  localparam int K_W  = $clog2(B_W);

  localparam logic [K_W-1:0] K_LAST  = K_W'(B_W - 1);
  localparam logic [NW-1:0]  RND_ADD = (ROUND != 0 && S > 0) ? (NW'(1) << ((SH_R > 0) ? SH_R - 1 : 0)) : '0;
  localparam logic signed [NW-1:0] P_MAX = {{(NW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [NW-1:0] P_MIN = {{(NW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  generate
    if (A_W < 2 || B_W < 2 || OUT_W < 2) begin : g_bad_params
      $error("fxp_mult_seq: A_W, B_W and OUT_W must all be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state;
  logic signed [A_W-1:0]  a_reg;
  logic [B_W-1:0]         b_reg;
  logic signed [P_W-1:0]  acc;
  logic [K_W-1:0]         k;

  logic signed [P_W-1:0]  addend;
  logic signed [NW-1:0]   wide;
  logic signed [NW-1:0]   rounded;
  logic signed [NW-1:0]   scaled;
  logic                   above;
  logic                   below;
  logic [OUT_W-1:0]       norm_p;
  logic                   norm_ovf;

  assign addend = $signed({{B_W{a_reg[A_W-1]}}, a_reg}) <<< k;

  // Extra headroom in NW keeps the rounding add and any left shift exact before the range check.
  always_comb begin
    wide     = {{(NW - P_W){acc[P_W-1]}}, acc};
    rounded  = wide + $signed(RND_ADD);
    scaled   = (rounded >>> SH_R) <<< SH_L;
    above    = scaled > P_MAX;
    below    = scaled < P_MIN;
    norm_ovf = above | below;
    norm_p   = scaled[OUT_W-1:0];
    if (SAT != 0 && above) begin
      norm_p = P_MAX[OUT_W-1:0];
    end else if (SAT != 0 && below) begin
      norm_p = P_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= MUL;
          end
        end
        MUL: begin
          // The top bit of b carries negative weight in two's complement.
          if (b_reg[k]) begin
            acc <= (k == K_LAST) ? acc - addend : acc + addend;
          end
          if (k == K_LAST) begin
            state <= NORM;
          end else begin
            k <= k + K_W'(1);
          end
        end
        NORM: begin
          out_p     <= norm_p;
          out_ovf   <= norm_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_mult_seq.sv
// Randomised and directed bench for fxp_mult_seq against an integer-arithmetic reference model.
// Three instances: default formats, default widths with truncate/wrap, and an integer sweep format.
module tb_fxp_mult_seq;
  localparam int A_W = 7, A_FRAC = 4, B_W = 14, B_FRAC = 10, OUT_W = 14, OUT_FRAC = 10;
  localparam int A2_W = 8, B2_W = 8, OUT2_W = 16, OUT2_FRAC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, iv, or_rdy;
  logic [A_W-1:0] ia;
  logic [B_W-1:0] ib;
  logic ir0, ov0, f0, ir1, ov1, f1;
  logic [OUT_W-1:0] p0, p1;

  logic iv2, or2;
  logic [A2_W-1:0] ia2;
  logic [B2_W-1:0] ib2;
  logic ir2, ov2, f2;
  logic [OUT2_W-1:0] p2;

  int errors = 0;
  int checks = 0;

  fxp_mult_seq #(.ROUND(1), .SAT(1)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir0), .in_a(ia), .in_b(ib),
    .out_valid(ov0), .out_ready(or_rdy), .out_p(p0), .out_ovf(f0));

  fxp_mult_seq #(.ROUND(0), .SAT(0)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir1), .in_a(ia), .in_b(ib),
    .out_valid(ov1), .out_ready(or_rdy), .out_p(p1), .out_ovf(f1));

  fxp_mult_seq #(.A_W(A2_W), .A_FRAC(0), .B_W(B2_W), .B_FRAC(0), .OUT_W(OUT2_W),
                 .OUT_FRAC(OUT2_FRAC), .ROUND(1), .SAT(1)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_a(ia2), .in_b(ib2),
    .out_valid(ov2), .out_ready(or2), .out_p(p2), .out_ovf(f2));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact product, scaled to the output format, then range-checked with saturation or wrap.
  function automatic void model(input longint a, input longint b, input int pf, input int out_frac,
                                input int out_w, input int rnd, input int sat,
                                output longint p, output longint ovf);
    longint prod, v, hi, lo, m;
    int s;
    prod = a * b;
    s = pf - out_frac;
    if (s > 0) begin
      if (rnd != 0) prod = prod + (longint'(1) << (s - 1));
      v = prod >>> s;
    end else begin
      v = prod * (longint'(1) << (-s));
    end
    hi = (longint'(1) << (out_w - 1)) - 1;
    lo = -hi - 1;
    ovf = (v > hi || v < lo) ? 1 : 0;
    if (ovf == 0) p = v;
    else if (sat != 0) p = (v > hi) ? hi : lo;
    else begin
      m = v & ((longint'(1) << out_w) - 1);
      if (m > hi) m = m - (longint'(1) << out_w);
      p = m;
    end
  endfunction

  task automatic run_op(input int a, input int b, input int hold, input bit junk, input string tag);
    longint ep0, ef0, ep1, ef1;
    int edges;
    bit busy;
    model(a, b, A_FRAC + B_FRAC, OUT_FRAC, OUT_W, 1, 1, ep0, ef0);
    model(a, b, A_FRAC + B_FRAC, OUT_FRAC, OUT_W, 0, 0, ep1, ef1);
    @(negedge clk);
    iv = 1'b1; ia = A_W'(a); ib = B_W'(b);
    chk({tag, " in_ready"}, ir0, 1);
    @(posedge clk); #1;
    edges = 1;  // the accepting edge counts as edge 1
    busy = 1'b0;
    while (!ov0 && edges < 200) begin
      if (ir0 || ir1) busy = 1'b1;
      iv = junk;
      if (junk) begin
        ia = A_W'($urandom);
        ib = B_W'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    iv = 1'b0;
    if (ir0) busy = 1'b1;
    chk({tag, " latency"}, edges, B_W + 2);
    chk({tag, " busy_ready"}, busy, 0);
    chk({tag, " p_rs"}, longint'($signed(p0)), ep0);
    chk({tag, " ovf_rs"}, f0, ef0);
    chk({tag, " valid_tw"}, ov1, 1);
    chk({tag, " p_tw"}, longint'($signed(p1)), ep1);
    chk({tag, " ovf_tw"}, f1, ef1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold_p"}, longint'($signed(p0)), ep0);
      chk({tag, " hold_valid"}, ov0, 1);
      chk({tag, " hold_ready"}, ir0, 0);
    end
    or_rdy = 1'b1;
    @(posedge clk); #1;
    or_rdy = 1'b0;
    chk({tag, " valid_clr"}, ov0, 0);
    chk({tag, " ready_back"}, ir0, 1);
    $display("op %s a=%0d b=%0d p=%0d ovf=%0d p_tw=%0d ovf_tw=%0d", tag, a, b, ep0, ef0, ep1, ef1);
  endtask

  task automatic run_op2(input int a, input int b, input string tag);
    longint ep, ef;
    int edges;
    model(a, b, 0, OUT2_FRAC, OUT2_W, 1, 1, ep, ef);
    @(negedge clk);
    iv2 = 1'b1; ia2 = A2_W'(a); ib2 = B2_W'(b);
    @(posedge clk); #1;
    iv2 = 1'b0;
    edges = 1;
    while (!ov2 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, " latency"}, edges, B2_W + 2);
    chk({tag, " p"}, longint'($signed(p2)), ep);
    chk({tag, " ovf"}, f2, ef);
    or2 = 1'b1;
    @(posedge clk); #1;
    or2 = 1'b0;
    chk({tag, " valid_clr"}, ov2, 0);
    $display("op %s a=%0d b=%0d p=%0d ovf=%0d", tag, a, b, ep, ef);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; iv = 1'b0; or_rdy = 1'b0; ia = '0; ib = '0;
    iv2 = 1'b0; or2 = 1'b0; ia2 = '0; ib2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", ov0, 0);
    chk("reset p", longint'($signed(p0)), 0);
    chk("reset ovf", f0, 0);
    chk("reset ready", ir0, 0);
    chk("reset valid2", ov2, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", ir0, 1);
    chk("ready2 after reset", ir2, 1);

    run_op(16, 1024, 5, 1'b0, "unity");
    run_op(-64, -8192, 0, 1'b0, "sat_pos");
    run_op(-64, 8191, 0, 1'b0, "sat_neg");
    run_op(1, 8, 0, 1'b0, "round_pos");
    run_op(-1, 8, 0, 1'b0, "round_neg");
    run_op(-64, -1, 0, 1'b0, "msb_a");
    run_op(3, -8192, 0, 1'b0, "msb_b");
    run_op(5, -300, 1, 1'b1, "ignore_in");

    // Abort an operation at k=5 with a single reset edge.
    @(negedge clk);
    iv = 1'b1; ia = A_W'(-20); ib = B_W'(777);
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort valid", ov0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort ready", ir0, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov0) seen = 1'b1;
    end
    chk("abort no result", seen, 0);
    run_op(-20, 777, 0, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 127)) - 64, int'($urandom_range(0, 16383)) - 8192,
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
    end

    run_op2(-128, -128, "sweep_sat");
    run_op2(3, 5, "sweep_small");
    for (int i = 0; i < 10; i++) begin
      run_op2(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, "sweep_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
